// File: rtl/ppi_control_unit.sv
// ppi_control_unit
// Write-side controller for a PPI-style parallel port block. A CPU write is
// captured while CS_n/WR_n are low and committed when WR_n rises, updating the
// mode word, the port output latches or a single port C bit (BSR). Port A
// supports mode-1 output handshake (OBF_A_n / ACK_A_n / INTR_A).
//
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   CS_n, WR_n, A, D_IN   CPU write interface
//   ACK_A_n               port A mode-1 acknowledge (active low)
//   MODE_WORD             latched mode control word
//   PORTA/B/C_OUT         output latches (PORTC_OUT has handshake bits merged)
//   PA/PB/PCU/PCL_DIR     group directions, 1=input 0=output
//   OBF_A_n, INTR_A       port A handshake outputs
//   MODE_ERR              mode word asks for an unsupported mode
//
// Write FSM
//   state  | meaning
//   IDLE   | no write in progress
//   ACTIVE | write strobe low, A/D_IN captured every cycle until WR_n rises
module ppi_control_unit (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CS_n,
    input  logic       WR_n,
    input  logic [1:0] A,
    input  logic [7:0] D_IN,
    input  logic       ACK_A_n,
    output logic [7:0] MODE_WORD,
    output logic [7:0] PORTA_OUT,
    output logic [7:0] PORTB_OUT,
    output logic [7:0] PORTC_OUT,
    output logic       PA_DIR,
    output logic       PB_DIR,
    output logic       PCU_DIR,
    output logic       PCL_DIR,
    output logic       OBF_A_n,
    output logic       INTR_A,
    output logic       MODE_ERR
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } wr_state_t;

    wr_state_t   state;
    wr_state_t   state_nx;
    logic        capture;
    logic        commit;
    logic [1:0]  a_cap;
    logic [7:0]  d_cap;
    logic [7:0]  mode_q;
    logic [7:0]  pa_q;
    logic [7:0]  pb_q;
    logic [7:0]  pc_q;
    logic        obf_n_q;
    logic        intr_q;
    logic        inte_q;
    logic        ack_q;
    logic        mode1a;
    logic [2:0]  bsr_sel;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Rising WR_n completes the write even if CS_n rises in the same cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!CS_n && !WR_n) state_nx = ACTIVE;
            ACTIVE:  if (WR_n || CS_n)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        capture = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE:    capture = !CS_n && !WR_n;
            ACTIVE: begin
                capture = !CS_n && !WR_n;
                commit  = WR_n;
            end
            default: ;
        endcase
    end

    // Unsupported groups fall back to mode 0, so mode 1 needs a clean word.
    assign MODE_ERR = mode_q[6] | mode_q[2] | ((mode_q[6:5] == 2'b01) & mode_q[4]);
    assign mode1a   = (mode_q[6:5] == 2'b01) & ~mode_q[4] & ~MODE_ERR;
    assign bsr_sel  = d_cap[3:1];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_cap   <= 2'b00;
            d_cap   <= 8'h00;
            mode_q  <= 8'h9B;
            pa_q    <= 8'h00;
            pb_q    <= 8'h00;
            pc_q    <= 8'h00;
            obf_n_q <= 1'b1;
            intr_q  <= 1'b0;
            inte_q  <= 1'b0;
            ack_q   <= 1'b1;
        end else begin
            ack_q <= ACK_A_n;
            if (capture) begin
                a_cap <= A;
                d_cap <= D_IN;
            end
            if (mode1a) begin
                if (!ACK_A_n) obf_n_q <= 1'b1;
                if (!ack_q && ACK_A_n) intr_q <= inte_q;
            end
            // Commit is applied after the ACK handling so it wins on a collision.
            if (commit) begin
                case (a_cap)
                    2'b00: begin
                        pa_q <= d_cap;
                        if (mode1a) begin
                            obf_n_q <= 1'b0;
                            intr_q  <= 1'b0;
                        end
                    end
                    2'b01: pb_q <= d_cap;
                    2'b10: begin
                        // Bits 7, 6, 3 carry handshake signals in mode 1.
                        if (mode1a) pc_q <= {pc_q[7:6], d_cap[5:4], pc_q[3], d_cap[2:0]};
                        else        pc_q <= d_cap;
                    end
                    default: begin
                        if (d_cap[7]) begin
                            mode_q  <= d_cap;
                            pa_q    <= 8'h00;
                            pb_q    <= 8'h00;
                            pc_q    <= 8'h00;
                            obf_n_q <= 1'b1;
                            intr_q  <= 1'b0;
                            inte_q  <= 1'b0;
                        end else if (mode1a && bsr_sel == 3'd6) begin
                            inte_q <= d_cap[0];
                        end else if (!(mode1a && (bsr_sel == 3'd7 || bsr_sel == 3'd3))) begin
                            pc_q[bsr_sel] <= d_cap[0];
                        end
                    end
                endcase
            end
        end
    end

    assign MODE_WORD = mode_q;
    assign PORTA_OUT = pa_q;
    assign PORTB_OUT = pb_q;
    assign PORTC_OUT = mode1a ? {obf_n_q, inte_q, pc_q[5:4], intr_q, pc_q[2:0]} : pc_q;
    assign PA_DIR    = mode_q[4];
    assign PCU_DIR   = mode_q[3];
    assign PB_DIR    = mode_q[1];
    assign PCL_DIR   = mode_q[0];
    assign OBF_A_n   = obf_n_q;
    assign INTR_A    = intr_q;

endmodule
